// File: rtl/input_debounce_pkg.sv
// input_debounce_pkg: shared clocking and sizing defaults for the switch debouncer.
package input_debounce_pkg;
    localparam int CLK_HZ            = 50_000_000;
    localparam int DEBOUNCE_MS       = 10;
    localparam int DEF_STABLE_CYCLES = CLK_HZ / 1000 * DEBOUNCE_MS;
    localparam int DEF_NCH           = 2;
endpackage

// File: rtl/debounce_ch.sv
// debounce_ch: one switch channel, synchronizer plus stable-window filter; INPUT_DEBOUNCE_PULSE_EN adds edge pulses.
module debounce_ch
    import input_debounce_pkg::*;
#(
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES,
    parameter int CNT_W         = $clog2(DEF_STABLE_CYCLES)
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic db,
    output logic rise_p,
    output logic fall_p
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(STABLE_CYCLES - 1);

    logic             s1, s2;
    logic [CNT_W-1:0] cnt;
    logic             flip;

    assign flip = (s2 != db) && (cnt == LAST);

    // synchronize raw, then accept s2 only after STABLE_CYCLES consecutive disagreeing cycles
    always_ff @(posedge clk) begin
        if (rst) begin
            s1  <= 1'b0;
            s2  <= 1'b0;
            cnt <= '0;
            db  <= 1'b0;
        end else begin
            s1  <= raw;
            s2  <= s1;
            cnt <= (s2 == db || flip) ? '0 : cnt + CNT_W'(1);
            if (flip) db <= s2;
        end
    end

`ifdef INPUT_DEBOUNCE_PULSE_EN
    // pulses land in the same cycle db takes its new value
    always_ff @(posedge clk) begin
        rise_p <= !rst && flip && s2;
        fall_p <= !rst && flip && !s2;
    end
`else
    assign rise_p = 1'b0;
    assign fall_p = 1'b0;
`endif
endmodule

// File: rtl/input_debounce.sv
// input_debounce: NCH independent switch debouncers; INPUT_DEBOUNCE_PULSE_EN enables rise_p/fall_p.
module input_debounce
    import input_debounce_pkg::*;
#(
    parameter int NCH           = DEF_NCH,
    parameter int STABLE_CYCLES = DEF_STABLE_CYCLES
) (
    input  logic           clk,
    input  logic           rst,
    input  logic [NCH-1:0] raw_in,
    output logic [NCH-1:0] db_out,
    output logic [NCH-1:0] rise_p,
    output logic [NCH-1:0] fall_p
);
    localparam int CNT_W = $clog2(STABLE_CYCLES);

    genvar i;
    generate
        for (i = 0; i < NCH; i++) begin : g_ch
            debounce_ch #(
                .STABLE_CYCLES(STABLE_CYCLES),
                .CNT_W        (CNT_W)
            ) u_ch (
                .clk   (clk),
                .rst   (rst),
                .raw   (raw_in[i]),
                .db    (db_out[i]),
                .rise_p(rise_p[i]),
                .fall_p(fall_p[i])
            );
        end
    endgenerate
endmodule

// File: tb/tb_input_debounce.sv
// tb_input_debounce: directed and random checks of input_debounce against a sliding-window reference.
module tb_input_debounce;
    localparam int S = 4;
    localparam int N = 2;
`ifdef INPUT_DEBOUNCE_PULSE_EN
    localparam bit PEN = 1'b1;
`else
    localparam bit PEN = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] raw_in = '0;
    logic [N-1:0] db_out, rise_p, fall_p;

    input_debounce #(.NCH(N), .STABLE_CYCLES(S)) dut (
        .clk   (clk),
        .rst   (rst),
        .raw_in(raw_in),
        .db_out(db_out),
        .rise_p(rise_p),
        .fall_p(fall_p)
    );

    always #5 clk = ~clk;

    // hist[j] is the raw value sampled j+1 edges before the current one
    logic [N-1:0] hist [S+1];
    logic [N-1:0] m_db = '0, m_rise = '0, m_fall = '0;
    int checks = 0, errors = 0;

    task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // a channel's output flips once the last S synchronized samples all disagree with it
    task automatic step(input logic [N-1:0] r, input logic x);
        logic [N-1:0] fl;
        raw_in = r;
        rst = x;
        @(posedge clk);
        if (x) begin
            foreach (hist[j]) hist[j] = '0;
            m_db = '0;
            m_rise = '0;
            m_fall = '0;
        end else begin
            fl = '1;
            for (int j = 1; j <= S; j++) fl &= hist[j] ^ m_db;
            m_rise = PEN ? (fl & ~m_db) : '0;
            m_fall = PEN ? (fl & m_db) : '0;
            m_db = m_db ^ fl;
            for (int j = S; j > 0; j--) hist[j] = hist[j-1];
            hist[0] = r;
        end
        #1;
        chk("db_out", db_out, m_db);
        chk("rise_p", rise_p, m_rise);
        chk("fall_p", fall_p, m_fall);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        int rises;
        int any;
        logic [N-1:0] r;
        foreach (hist[j]) hist[j] = '0;

        // reset held with both switches high
        repeat (3) begin
            step(2'b11, 1'b1);
            chk("reset_db", db_out, 2'b00);
        end
        step(2'b11, 1'b0);
        chk("post_reset_db", db_out, 2'b00);
        chk("post_reset_pulse", rise_p | fall_p, 2'b00);

        // clean press on channel 0
        step(2'b00, 1'b1);
        n = 0;
        do begin step(2'b01, 1'b0); n++; end while (!db_out[0] && n < 20);
        chk_int("press_latency", n, 6);
        chk("press_rise", rise_p, {1'b0, PEN});
        chk("press_ch1", db_out, 2'b01);

        // release on channel 0
        n = 0;
        do begin step(2'b00, 1'b0); n++; end while (db_out[0] && n < 20);
        chk_int("release_latency", n, 6);
        chk("release_fall", fall_p, {1'b0, PEN});
        step(2'b00, 1'b0);
        chk("release_once", fall_p, 2'b00);

        // bouncing press: window restarts after each low sample
        step(2'b00, 1'b1);
        rises = 0;
        n = 0;
        for (int k = 0; k < 20; k++) begin
            r = {1'b0, (k != 2 && k != 5)};
            step(r, 1'b0);
            rises += rise_p[0];
            if (db_out[0] && n == 0) n = k + 1;
        end
        chk_int("bounce_latency", n, 12);
        chk_int("bounce_rises", rises, PEN ? 1 : 0);

        // three-cycle glitch on channel 1 is rejected
        step(2'b00, 1'b1);
        any = 0;
        for (int k = 0; k < 14; k++) begin
            step(k < 3 ? 2'b10 : 2'b00, 1'b0);
            any += db_out[1] + rise_p[1] + fall_p[1];
        end
        chk_int("glitch_ignored", any, 0);

        // simultaneous press on both channels
        step(2'b00, 1'b1);
        n = 0;
        do begin step(2'b11, 1'b0); n++; end while (db_out != 2'b11 && n < 20);
        chk_int("both_latency", n, 6);
        chk("both_rise", rise_p, {PEN, PEN});

        // reset in the middle of a count discards progress
        step(2'b11, 1'b1);
        repeat (4) step(2'b11, 1'b0);
        step(2'b11, 1'b1);
        chk("midreset_db", db_out, 2'b00);
        n = 0;
        do begin step(2'b11, 1'b0); n++; end while (db_out != 2'b11 && n < 20);
        chk_int("midreset_latency", n, 6);

        // random switch activity with occasional resets
        r = '0;
        for (int k = 0; k < 600; k++) begin
            for (int c = 0; c < N; c++)
                if ($urandom_range(0, 5) == 0) r[c] = ~r[c];
            step(r, $urandom_range(0, 99) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
